// File: rtl/sub3_pkg.sv
// sub3_pkg: shared types and constants for the serial three-operand subtractor.
//   DATA_W       operand width (16)
//   RES_W        result width (18, two's complement)
//   sub3_state_t FSM state encoding {IDLE, RUN, DONE}
//   borrow_t     2-bit ripple borrow (range 0..2)
//   borrow_ext() maps the final borrow onto result bits [17:16]
package sub3_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned RES_W  = 18;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub3_state_t;

    typedef logic [1:0] borrow_t;

    // The final borrow counts whole units of 2^16 still owed, so the top two result bits
    // are simply -bw mod 4: 0 -> 00, 1 -> 11, 2 -> 10.
    function automatic logic [1:0] borrow_ext(borrow_t bw);
        return 2'(2'd0 - bw);
    endfunction

endpackage

// File: rtl/sub3_serial_16bit_if.sv
// sub3_serial_16bit_if: handshake and data bundle for sub3_serial_16bit.
//   in_valid/in_ready   operand handshake (A, B, C, Bin)
//   out_valid/out_ready result handshake (D)
//   neg, zero           result flags, present only when SUB3_FLAGS_EN is defined
// Modports: master drives operands and out_ready; slave is the subtractor.
interface sub3_serial_16bit_if;
    import sub3_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] C;
    logic              Bin;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  D;
`ifdef SUB3_FLAGS_EN
    logic              neg;
    logic              zero;
`endif

    modport master (
        output in_valid, A, B, C, Bin, out_ready,
        input  in_ready, out_valid, D
`ifdef SUB3_FLAGS_EN
        , input neg, zero
`endif
    );

    modport slave (
        input  in_valid, A, B, C, Bin, out_ready,
        output in_ready, out_valid, D
`ifdef SUB3_FLAGS_EN
        , output neg, zero
`endif
    );

endinterface

// File: rtl/sub3_digit_slice.sv
// sub3_digit_slice: combinational one-digit step of x = a - b - c - bw_in.
//   a, b, c  DIGIT_W-bit operand digits
//   bw_in    incoming borrow (0..2)
//   d        x mod 2^DIGIT_W
//   bw_out   -floor(x / 2^DIGIT_W), range 0..2
module sub3_digit_slice
    import sub3_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic [DIGIT_W-1:0] c,
    input  borrow_t            bw_in,
    output logic [DIGIT_W-1:0] d,
    output borrow_t            bw_out
);

    // x lies in [-2^(W+1), 2^W), so W+2 bits hold it exactly in two's complement.
    logic [DIGIT_W+1:0] x;

    always_comb begin
        x      = {2'b00, a} - {2'b00, b} - {2'b00, c} - {{DIGIT_W{1'b0}}, bw_in};
        d      = x[DIGIT_W-1:0];
        // Top bits are floor(x / 2^W) in {0, -1, -2}; negate to get the borrow.
        bw_out = 2'(2'd0 - x[DIGIT_W+1:DIGIT_W]);
    end

endmodule

// File: rtl/sub3_serial_16bit.sv
// sub3_serial_16bit: digit-serial D = A - B - C - Bin, 18-bit two's-complement result.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   sub3_serial_16bit_if.slave (in_valid/in_ready, A, B, C, Bin,
//         out_valid/out_ready, D, and neg/zero when SUB3_FLAGS_EN is defined)
// DIGIT_W bits (1, 2, 4, 8 or 16) are processed per RUN cycle, LSB first; latency 16/DIGIT_W.
// Optional feature macro: SUB3_FLAGS_EN adds registered neg and zero result flags.
module sub3_serial_16bit
    import sub3_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4
) (
    input logic                clk,
    input logic                rst,
    sub3_serial_16bit_if.slave bus
);

    localparam int unsigned N     = DATA_W / DIGIT_W;
    localparam int unsigned CNT_W = 5;

    sub3_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d;
    borrow_t           bw_q, bw_d;
    logic [RES_W-1:0]  d_q, d_d;
`ifdef SUB3_FLAGS_EN
    logic              neg_q, neg_d;
    logic              zero_q, zero_d;
`endif

    logic [DIGIT_W-1:0]        dig;
    borrow_t                   bw_next;
    logic [DATA_W+DIGIT_W-1:0] res_cat;
    logic                      accept;
    logic                      last;

    assign accept = bus.in_valid && (state_q == IDLE);
    assign last   = (state_q == RUN) && (cnt_q == CNT_W'(N - 1));

    sub3_digit_slice #(
        .DIGIT_W (DIGIT_W)
    ) u_slice (
        .a      (a_q[DIGIT_W-1:0]),
        .b      (b_q[DIGIT_W-1:0]),
        .c      (c_q[DIGIT_W-1:0]),
        .bw_in  (bw_q),
        .d      (dig),
        .bw_out (bw_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last)         state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from registers only
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.D         = d_q;
`ifdef SUB3_FLAGS_EN
        bus.neg       = neg_q;
        bus.zero      = zero_q;
`endif
    end

    // Datapath next state
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        bw_d    = bw_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        // New digit enters at bit 15 and the low 16 result bits slide right.
        res_cat = {dig, d_q[DATA_W-1:0]};
`ifdef SUB3_FLAGS_EN
        neg_d   = neg_q;
        zero_d  = zero_q;
`endif
        if (accept) begin
            a_d   = bus.A;
            b_d   = bus.B;
            c_d   = bus.C;
            bw_d  = {1'b0, bus.Bin};
            cnt_d = '0;
        end else if (state_q == RUN) begin
            a_d                = a_q >> DIGIT_W;
            b_d                = b_q >> DIGIT_W;
            c_d                = c_q >> DIGIT_W;
            bw_d               = bw_next;
            cnt_d              = cnt_q + CNT_W'(1);
            d_d[DATA_W-1:0]    = res_cat[DATA_W+DIGIT_W-1:DIGIT_W];
            if (last) begin
                d_d[RES_W-1:DATA_W] = borrow_ext(bw_next);
`ifdef SUB3_FLAGS_EN
                neg_d  = d_d[RES_W-1];
                zero_d = (d_d == '0);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            bw_q   <= '0;
            cnt_q  <= '0;
            d_q    <= '0;
`ifdef SUB3_FLAGS_EN
            neg_q  <= 1'b0;
            zero_q <= 1'b1;
`endif
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            bw_q   <= bw_d;
            cnt_q  <= cnt_d;
            d_q    <= d_d;
`ifdef SUB3_FLAGS_EN
            neg_q  <= neg_d;
            zero_q <= zero_d;
`endif
        end
    end

endmodule

// File: tb/tb_sub3_serial_16bit.sv
// tb_sub3_serial_16bit: scoreboard bench for sub3_serial_16bit (DIGIT_W = 4).
// Stimulus pushes exact integer results of A - B - C - Bin; a monitor pops on each
// output handshake and also checks latency and the return to IDLE.
module tb_sub3_serial_16bit;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned N       = 16 / DIGIT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sub3_serial_16bit_if bus ();

    sub3_serial_16bit #(
        .DIGIT_W (DIGIT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors     = 0;
    int checks     = 0;
    int cyc        = 0;
    int ready_mode = 0;  // 0 random, 1 hold low, 2 hold high

    logic [17:0] exp_q[$];
    int          acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [17:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic bin);
        int r;
        r = int'(a) - int'(b) - int'(c) - int'(bin);
        return 18'(r);
    endfunction

    // Consumer readiness, changed just after each rising edge
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.out_ready = 1'b0;
                2:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        prev_valid;
        logic        ready_due;
        logic [17:0] e;
        int          a;
        prev_valid = 1'b0;
        ready_due  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ready_due) begin
                check("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
                ready_due = 1'b0;
            end
            if (bus.out_valid && !prev_valid) begin
                if (acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 (t=%0t)",
                             $time);
                end else begin
                    a = acc_q.pop_front();
                    check("latency", 32'(cyc - a), N);
                end
            end
            if (bus.out_valid) check("in_ready_low_in_done", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid && bus.out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result_without_request: got D=0x%0h, expected none", bus.D);
                end else begin
                    e = exp_q.pop_front();
                    check("D", 32'(bus.D), 32'(e));
`ifdef SUB3_FLAGS_EN
                    check("neg", 32'(bus.neg), 32'(e[17]));
                    check("zero", 32'(bus.zero), 32'(e == 18'h0));
`endif
                    ready_due = 1'b1;
                end
            end
            prev_valid = bus.out_valid;
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic bin);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready=0, expected 1");
            return;
        end
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.C        = c;
        bus.Bin      = bin;
        exp_q.push_back(ref_sub(a, b, c, bin));
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        // Scramble operands so late sampling would be caught
        bus.in_valid = 1'b0;
        bus.A        = 16'($urandom);
        bus.B        = 16'($urandom);
        bus.C        = 16'($urandom);
        bus.Bin      = 1'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [17:0] held;
        int          w;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.C        = '0;
        bus.Bin      = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_D", 32'(bus.D), 32'd0);
`ifdef SUB3_FLAGS_EN
        check("reset_neg", 32'(bus.neg), 32'd0);
        check("reset_zero", 32'(bus.zero), 32'd1);
`endif
        rst = 1'b0;

        // Directed corner cases
        issue(16'h0005, 16'h0002, 16'h0001, 1'b0);
        issue(16'h0000, 16'hFFFF, 16'hFFFF, 1'b1);
        issue(16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        issue(16'h1000, 16'h1000, 16'h0000, 1'b1);
        issue(16'h0000, 16'h0000, 16'h0000, 1'b0);
        drain();

        // Backpressure: hold DONE for 10 cycles while offering new operands
        ready_mode = 1;
        issue(16'h1234, 16'h0234, 16'h0100, 1'b0);
        held = ref_sub(16'h1234, 16'h0234, 16'h0100, 1'b0);
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("bp_reached_done", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.A        = 16'($urandom);
            bus.B        = 16'($urandom);
            bus.C        = 16'($urandom);
            bus.Bin      = 1'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_D_stable", 32'(bus.D), 32'(held));
        end
        bus.in_valid = 1'b0;
        ready_mode   = 2;
        issue(16'h8000, 16'h0001, 16'h7FFF, 1'b1);
        drain();
        ready_mode = 0;

        // Reset during RUN digit 2
        issue(16'h4321, 16'h1111, 16'h0101, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_D", 32'(bus.D), 32'd0);
`ifdef SUB3_FLAGS_EN
        check("abort_neg", 32'(bus.neg), 32'd0);
        check("abort_zero", 32'(bus.zero), 32'd1);
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_out_valid", 32'(bus.out_valid), 32'd0);
        end
        issue(16'h0100, 16'h0001, 16'h0001, 1'b0);
        drain();

        // Random operands
        for (int i = 0; i < 40; i++) begin
            issue(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sub3_serial_16bit.md
# sub3_serial_16bit

Multi-cycle 16-bit three-operand subtractor computing D = A − B − C − Bin, the inverse counterpart to the three-operand ripple adder in the arithmetic-circuits comparison set. It processes one DIGIT_W-bit digit per clock, LSB first, through a 2-bit ripple borrow register. It uses a valid/ready handshake on both sides and produces an 18-bit two's-complement result covering the full range −131071 … +65535.

## Interface
- DIGIT_W, default 4: bits processed per cycle; legal values are 1, 2, 4, 8 and 16. N = 16/DIGIT_W RUN cycles.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and Bin valid
- in_ready  output  1  block can accept; high only in IDLE
- A  input  16  minuend, unsigned
- B  input  16  subtrahend 1, unsigned
- C  input  16  subtrahend 2, unsigned
- Bin  input  1  external borrow-in
- out_valid  output  1  D valid; high only in DONE
- out_ready  input  1  consumer accepts D
- D  output  18  two's-complement result
- neg  output  1  D[17]; present only with SUB3_FLAGS_EN
- zero  output  1  D == 0; present only with SUB3_FLAGS_EN

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:** in_ready=1. On in_valid && in_ready:
  - capture A, B and C into shift registers;
  - set borrow register bw to {1'b0, Bin};
  - clear the digit counter;
  - go to RUN.
- **RUN, per cycle k (0 … N−1):**
  - x = A_k − B_k − C_k − bw, where A_k, B_k and C_k are the low DIGIT_W bits of the shift registers;
  - result digit = x mod 2^DIGIT_W, shifted into D from the top;
  - new bw = −floor(x / 2^DIGIT_W), range 0 … 2;
  - operand registers shift right by DIGIT_W.
  - After digit N−1, go to DONE.
- **Final extension:** bits D[17:16] are set from the final bw value:
  - bw 0 → 2'b00;
  - bw 1 → 2'b11;
  - bw 2 → 2'b10.
- **DONE:** out_valid=1 and D is held stable. On out_valid && out_ready, go to IDLE.
- **Arithmetic:** D equals the mathematically exact A − B − C − Bin modulo 2^18. Overflow is not possible.
- **Input gating:** in_valid is ignored outside IDLE. Operand inputs are sampled only at the accepting edge.
- **out_ready:** ignored outside DONE.
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, D=0, bw=0, counter=0. With SUB3_FLAGS_EN: neg=0, zero=1.
- **Reset mid-operation (RUN or DONE):** the operation is aborted and no out_valid pulse is produced. The next cycle is IDLE.

## Timing
- **Accept edge E0:** the in_valid && in_ready handshake. State is RUN from E0 to E_N.
- **Result visibility:** out_valid and the final D are visible after edge E_N, giving latency N cycles (4 for DIGIT_W=4, 1 for DIGIT_W=16).
- **Intermediate D:** D is not guaranteed stable while in RUN; its value is only defined when out_valid=1.
- **Output hold:** DONE holds for at least one cycle and indefinitely while out_ready=0.
- **Return to IDLE:** in_ready rises in the cycle after the output handshake edge.
- **Throughput:** minimum initiation interval is N+2 cycles. There is no overlap of consecutive operations.
- **Output paths:** in_ready and out_valid are decoded directly from the state register. There is no combinational path from any input to any output.

## Configuration
- **SUB3_FLAGS_EN defined:**
  - ports neg and zero exist, registered alongside D;
  - both are valid whenever out_valid=1;
  - zero=1 iff D==18'h0.
- **SUB3_FLAGS_EN undefined:** both ports and their logic are absent. All other behaviour is identical.

## Structure
- **Package sub3_pkg:**
  - localparams DATA_W=16, RES_W=18;
  - state enum typedef sub3_state_t {IDLE, RUN, DONE};
  - a 2-bit borrow typedef.
- **Sub-module sub3_digit_slice:** combinational, parameterized DIGIT_W.
  - Inputs: a, b, c digits and bw_in[1:0].
  - Outputs: d digit and bw_out[1:0].
  - Instantiated once in the top-level datapath.
- **Top level:** FSM, counter, shift registers, result register and the extension mapping.

## Test plan
- **Small positive:** DIGIT_W=4, A=16'h0005, B=16'h0002, C=16'h0001, Bin=0 → D=18'h00002, with out_valid 4 cycles after the accept edge.
- **Most negative:** A=0, B=16'hFFFF, C=16'hFFFF, Bin=1 → D=18'h20001 (−131071). With SUB3_FLAGS_EN, neg=1 and zero=0.
- **Maximum positive:** A=16'hFFFF, B=0, C=0, Bin=0 → D=18'h0FFFF. The final bw=0 path gives D[17:16]=2'b00.
- **Borrow-only minus one:** A=16'h1000, B=16'h1000, C=0, Bin=1 → D=18'h3FFFF (−1). Then A=B=C=0, Bin=0 → D=0, and zero=1 with SUB3_FLAGS_EN.
- **Backpressure:** hold out_ready=0 for 10 cycles in DONE.
  - D and out_valid stay stable; in_ready stays 0.
  - A new in_valid is ignored.
  - After release, the next operand set is accepted 2 cycles later and completes correctly.
- **Reset mid-operation:** assert rst for one cycle in RUN digit 2.
  - Next cycle: IDLE, in_ready=1, out_valid=0, D=0.
  - out_valid is never asserted for the aborted operation.
  - A following operation (A=16'h0100, B=16'h0001, C=16'h0001, Bin=0) gives D=18'h000FE.
